one_hot_stream_decoder: RTL and testbench

//  Multi-lane, pipelined one-hot -> binary decoder with valid/ready streaming handshake.

---
 rtl/one_hot_stream_decoder.sv | 112 +++++++++++
 tb/tb_one_hot_stream_decoder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/one_hot_stream_decoder.sv
// Multi-lane two-stage one-hot -> binary decoder with valid/ready handshake.
// Optional saturating error counter enabled by defining ONEHOT_ERRCNT_EN.
module one_hot_stream_decoder #(
   parameter int VALUES   = 8,
   parameter int LANES    = 1,
   parameter int PRIORITY = 0
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [LANES*VALUES-1:0]                       in_vector,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [LANES*((VALUES > 1) ? $clog2(VALUES) : 1)-1:0] out_binary,
   output logic [LANES-1:0]                              out_error,
   output logic [15:0]                                   err_count,
   input  logic                                          err_clear
);

   localparam int W = (VALUES > 1) ? $clog2(VALUES) : 1;

   logic                      s1_valid_q;
   logic [LANES*VALUES-1:0]   s1_vec_q;
   logic                      s2_valid_q;
   logic [LANES*W-1:0]        bin_q;
   logic [LANES-1:0]          err_q;

   logic                      s1_load;
   logic                      s2_load;
   logic [LANES*W-1:0]        bin_d;
   logic [LANES-1:0]          err_d;
   logic [LANES-1:0]          seen;
   logic [LANES-1:0]          multi;

   // S2 may refill in the same cycle it hands off, so in_ready sees out_ready combinationally.
   assign s2_load  = !s2_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign in_ready = s1_load;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
      end else if (s1_load) begin
         s1_valid_q <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (s1_load && in_valid) begin
         s1_vec_q <= in_vector;
      end
   end

   always_comb begin
      bin_d = '0;
      err_d = '0;
      seen  = '0;
      multi = '0;
      for (int l = 0; l < LANES; l++) begin
         for (int i = 0; i < VALUES; i++) begin
            if (s1_vec_q[l*VALUES + i]) begin
               if (PRIORITY == 0) begin
                  bin_d[l*W +: W] = bin_d[l*W +: W] | W'(i);
               end else if (!seen[l]) begin
                  bin_d[l*W +: W] = W'(i);
               end
               multi[l] = multi[l] | seen[l];
               seen[l]  = 1'b1;
            end
         end
         err_d[l] = !seen[l] || multi[l];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid_q <= 1'b0;
         bin_q      <= '0;
         err_q      <= '0;
      end else if (s2_load) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            bin_q <= bin_d;
            err_q <= err_d;
         end
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_binary = bin_q;
   assign out_error  = err_q;

`ifdef ONEHOT_ERRCNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk) begin
      if (reset || err_clear) begin
         err_cnt_q <= 16'h0;
      end else if (s2_valid_q && out_ready && (|err_q) && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'h1;
      end
   end

   assign err_count = err_cnt_q;
`else
   logic unused_err_clear;
   assign unused_err_clear = err_clear;
   assign err_count        = 16'h0;
`endif

endmodule

// File: tb/tb_one_hot_stream_decoder.sv
// Directed bench for one_hot_stream_decoder: three instances cover both decode modes
// and a 4-lane/5-value build; counter checks follow ONEHOT_ERRCNT_EN.
module tb_one_hot_stream_decoder;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   // dut0: VALUES=8, LANES=1, PRIORITY=0
   logic        iv0, ir0, ov0, or0, clr0;
   logic [7:0]  vec0;
   logic [2:0]  bin0;
   logic [0:0]  err0;
   logic [15:0] cnt0;

   // dut1: VALUES=8, LANES=1, PRIORITY=1
   logic        iv1, ir1, ov1, or1, clr1;
   logic [7:0]  vec1;
   logic [2:0]  bin1;
   logic [0:0]  err1;
   logic [15:0] cnt1;

   // dut4: VALUES=5, LANES=4, PRIORITY=0
   logic        iv4, ir4, ov4, or4, clr4;
   logic [19:0] vec4;
   logic [11:0] bin4;
   logic [3:0]  err4;
   logic [15:0] cnt4;

   one_hot_stream_decoder #(.VALUES(8), .LANES(1), .PRIORITY(0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .in_vector(vec0),
      .out_valid(ov0), .out_ready(or0), .out_binary(bin0), .out_error(err0),
      .err_count(cnt0), .err_clear(clr0));

   one_hot_stream_decoder #(.VALUES(8), .LANES(1), .PRIORITY(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_vector(vec1),
      .out_valid(ov1), .out_ready(or1), .out_binary(bin1), .out_error(err1),
      .err_count(cnt1), .err_clear(clr1));

   one_hot_stream_decoder #(.VALUES(5), .LANES(4), .PRIORITY(0)) dut4 (
      .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .in_vector(vec4),
      .out_valid(ov4), .out_ready(or4), .out_binary(bin4), .out_error(err4),
      .err_count(cnt4), .err_clear(clr4));

   task automatic test_reset;
      reset = 1'b1;
      iv0 = 0; vec0 = '0; or0 = 1; clr0 = 0;
      iv1 = 0; vec1 = '0; or1 = 1; clr1 = 0;
      iv4 = 0; vec4 = '0; or4 = 1; clr4 = 0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (ov0 !== 1'b0 || bin0 !== 3'd0 || err0 !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_outputs: valid=%b bin=%0d err=%b, want 0/0/0", ov0, bin0, err0);
      end
      n_checks++;
      if (cnt0 !== 16'h0 || ov4 !== 1'b0 || bin4 !== 12'h0 || err4 !== 4'h0) begin
         n_errors++;
         $display("FAIL reset_misc: cnt=%0h ov4=%b bin4=%0h err4=%0h, want all 0", cnt0, ov4, bin4, err4);
      end
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ir0 !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_in_ready: got %b want 1", ir0);
      end
   endtask

   task automatic test_basic;
      logic [7:0] v [3];
      logic [2:0] e [3];
      v[0] = 8'h01; v[1] = 8'h80; v[2] = 8'h10;
      e[0] = 3'd0;  e[1] = 3'd7;  e[2] = 3'd4;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c >= 2 && c < 5) begin
            n_checks++;
            if (ov0 !== 1'b1 || bin0 !== e[c-2] || err0 !== 1'b0) begin
               n_errors++;
               $display("FAIL basic_beat%0d: valid=%b bin=%0d err=%b, want 1/%0d/0", c-2, ov0, bin0, err0, e[c-2]);
            end
         end
         if (c == 5) begin
            n_checks++;
            if (ov0 !== 1'b0) begin
               n_errors++;
               $display("FAIL basic_drain: valid=%b want 0", ov0);
            end
         end
         or0  = 1'b1;
         iv0  = (c < 3);
         vec0 = (c < 3) ? v[c] : 8'h00;
         #1;
         if (c < 3) begin
            n_checks++;
            if (ir0 !== 1'b1) begin
               n_errors++;
               $display("FAIL basic_in_ready%0d: got %b want 1", c, ir0);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      logic [7:0] v [4];
      logic [2:0] e [4];
      logic [2:0] got [$];
      int idx = 0;
      int acc = 0;
      v[0] = 8'h02; v[1] = 8'h04; v[2] = 8'h08; v[3] = 8'h20;
      e[0] = 3'd1;  e[1] = 3'd2;  e[2] = 3'd3;  e[3] = 3'd5;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c >= 2) begin
            n_checks++;
            if (ov0 !== 1'b1 || bin0 !== 3'd1 || err0 !== 1'b0) begin
               n_errors++;
               $display("FAIL bp_hold%0d: valid=%b bin=%0d err=%b, want 1/1/0", c, ov0, bin0, err0);
            end
         end
         or0  = 1'b0;
         iv0  = 1'b1;
         vec0 = v[idx];
         #1;
         if (ir0) begin
            acc++;
            idx++;
         end
      end
      n_checks++;
      if (acc != 2 || ir0 !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_accepted: accepted=%0d in_ready=%b, want 2/0", acc, ir0);
      end
      for (int c = 0; c < 20 && got.size() < 4; c++) begin
         @(negedge clk);
         or0 = 1'b1;
         if (ov0) got.push_back(bin0);
         iv0  = (idx < 4);
         vec0 = (idx < 4) ? v[idx] : 8'h00;
         #1;
         if (iv0 && ir0) idx++;
      end
      iv0 = 1'b0;
      n_checks++;
      if (got.size() != 4) begin
         n_errors++;
         $display("FAIL bp_count: got %0d beats want 4", got.size());
      end
      for (int k = 0; k < got.size() && k < 4; k++) begin
         n_checks++;
         if (got[k] !== e[k]) begin
            n_errors++;
            $display("FAIL bp_order%0d: got %0d want %0d", k, got[k], e[k]);
         end
      end
      @(negedge clk);
      n_checks++;
      if (ov0 !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_no_dup: valid=%b want 0", ov0);
      end
   endtask

   task automatic test_priority;
      logic [7:0] v [3];
      logic [2:0] e0 [3];
      logic [2:0] e1 [3];
      v[0]  = 8'h0C; v[1]  = 8'h00; v[2]  = 8'hFF;
      e0[0] = 3'd3;  e0[1] = 3'd0;  e0[2] = 3'd7;
      e1[0] = 3'd2;  e1[1] = 3'd0;  e1[2] = 3'd0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c >= 2) begin
            n_checks++;
            if (ov0 !== 1'b1 || bin0 !== e0[c-2] || err0 !== 1'b1) begin
               n_errors++;
               $display("FAIL prio0_beat%0d: valid=%b bin=%0d err=%b, want 1/%0d/1", c-2, ov0, bin0, err0, e0[c-2]);
            end
            n_checks++;
            if (ov1 !== 1'b1 || bin1 !== e1[c-2] || err1 !== 1'b1) begin
               n_errors++;
               $display("FAIL prio1_beat%0d: valid=%b bin=%0d err=%b, want 1/%0d/1", c-2, ov1, bin1, err1, e1[c-2]);
            end
         end
         or0 = 1'b1; or1 = 1'b1;
         iv0 = (c < 3); iv1 = (c < 3);
         vec0 = (c < 3) ? v[c] : 8'h00;
         vec1 = vec0;
      end
      iv0 = 1'b0; iv1 = 1'b0;
   endtask

   task automatic test_lanes;
      logic [19:0] v [2];
      logic [11:0] e [2];
      logic [3:0]  ee [2];
      v[0] = {5'h00, 5'h03, 5'h01, 5'h10};
      e[0] = {3'd0, 3'd1, 3'd0, 3'd4};
      ee[0] = 4'b1100;
      v[1] = {5'h08, 5'h04, 5'h02, 5'h01};
      e[1] = {3'd3, 3'd2, 3'd1, 3'd0};
      ee[1] = 4'b0000;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c >= 2) begin
            n_checks++;
            if (ov4 !== 1'b1 || bin4 !== e[c-2] || err4 !== ee[c-2]) begin
               n_errors++;
               $display("FAIL lanes_beat%0d: valid=%b bin=%0h err=%b, want 1/%0h/%b", c-2, ov4, bin4, err4, e[c-2], ee[c-2]);
            end
         end
         or4  = 1'b1;
         iv4  = (c < 2);
         vec4 = (c < 2) ? v[c] : 20'h0;
      end
      iv4 = 1'b0;
   endtask

   task automatic stream0(input logic [7:0] v, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         or0 = 1'b1; iv0 = 1'b1; vec0 = v;
      end
      @(negedge clk);
      iv0 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_errcnt;
      @(negedge clk);
      or0 = 1'b1; iv0 = 1'b0; clr0 = 1'b1;
      @(negedge clk);
      clr0 = 1'b0;
      stream0(8'h00, 1);
      stream0(8'h03, 1);
      stream0(8'h0C, 1);
`ifdef ONEHOT_ERRCNT_EN
      n_checks++;
      if (cnt0 !== 16'd3) begin
         n_errors++;
         $display("FAIL errcnt_three: got %0d want 3", cnt0);
      end
      @(negedge clk); iv0 = 1'b1; vec0 = 8'h00;
      @(negedge clk); iv0 = 1'b0;
      @(negedge clk);
      if (!ov0) begin
         n_checks++;
         n_errors++;
         $display("FAIL errcnt_beat_ready: out_valid=%b want 1", ov0);
      end
      clr0 = 1'b1;
      @(negedge clk);
      clr0 = 1'b0;
      n_checks++;
      if (cnt0 !== 16'd0) begin
         n_errors++;
         $display("FAIL errcnt_clear_prio: got %0d want 0", cnt0);
      end
      stream0(8'h40, 1);
      n_checks++;
      if (cnt0 !== 16'd0) begin
         n_errors++;
         $display("FAIL errcnt_clean_beat: got %0d want 0", cnt0);
      end
      stream0(8'h00, 65534);
      n_checks++;
      if (cnt0 !== 16'hFFFE) begin
         n_errors++;
         $display("FAIL errcnt_near_max: got %0h want fffe", cnt0);
      end
      stream0(8'h00, 3);
      n_checks++;
      if (cnt0 !== 16'hFFFF) begin
         n_errors++;
         $display("FAIL errcnt_saturate: got %0h want ffff", cnt0);
      end
      @(negedge clk); clr0 = 1'b1;
      @(negedge clk); clr0 = 1'b0;
`else
      n_checks++;
      if (cnt0 !== 16'h0) begin
         n_errors++;
         $display("FAIL errcnt_disabled: got %0h want 0", cnt0);
      end
`endif
   endtask

   task automatic test_midstream_reset;
      @(negedge clk);
      or0 = 1'b0; iv0 = 1'b1; vec0 = 8'h03;
      @(negedge clk);
      vec0 = 8'h40;
      @(negedge clk);
      iv0 = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ov0 !== 1'b1 || bin0 !== 3'd1 || err0 !== 1'b1 || ir0 !== 1'b0) begin
         n_errors++;
         $display("FAIL mr_full: valid=%b bin=%0d err=%b in_ready=%b, want 1/1/1/0", ov0, bin0, err0, ir0);
      end
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ov0 !== 1'b0 || bin0 !== 3'd0 || err0 !== 1'b0 || cnt0 !== 16'h0) begin
         n_errors++;
         $display("FAIL mr_cleared: valid=%b bin=%0d err=%b cnt=%0h, want 0/0/0/0", ov0, bin0, err0, cnt0);
      end
      reset = 1'b0;
      or0   = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks++;
         if (ov0 !== 1'b0) begin
            n_errors++;
            $display("FAIL mr_stale%0d: valid=%b want 0", c, ov0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_priority();
      test_lanes();
      test_errcnt();
      test_midstream_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
